// File: rtl/mseq_pkg.sv
// Shared definitions for the m-sequence frame controller: FSM state
// encoding, LFSR geometry and the default (non-zero) LFSR seed.
package mseq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        PREAMBLE = 3'd2,
        PAYLOAD  = 3'd3,
        DONE     = 3'd4
    } state_e;

    // x^15 + x^14 + 1 : feedback taps on bits 14 and 13, output from bit 14
    localparam int                LFSR_W       = 15;
    localparam int                TAP_HI       = 14;
    localparam int                TAP_LO       = 13;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 15'h3BBB;

endpackage

// File: rtl/mseq_frame_ctrl_if.sv
// Serial bit stream from the frame controller to the modulator.
//
// Handshake: the master raises bit_valid with bit_out and holds both
// unchanged until a cycle in which bit_ready is also 1; that cycle (and
// only that one) transfers the bit. The slave may drive bit_ready at any
// time, independent of bit_valid.
interface mseq_frame_ctrl_if;
    logic bit_out;
    logic bit_valid;
    logic bit_ready;

    modport master (output bit_out, output bit_valid, input bit_ready);
    modport slave  (input bit_out, input bit_valid, output bit_ready);
endinterface

// File: rtl/mseq_lfsr15.sv
// 15-bit Fibonacci LFSR, x^15 + x^14 + 1. An all-zero seed would lock the
// register, so it is replaced by the default seed on load.
module mseq_lfsr15
    import mseq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic              lfsr_bit
);

    logic [LFSR_W-1:0] lfsr_state;

    // Load has priority over advance; output is always the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_state <= DEFAULT_SEED;
        end else if (load) begin
            lfsr_state <= (seed == '0) ? DEFAULT_SEED : seed;
        end else if (advance) begin
            lfsr_state <= {lfsr_state[LFSR_W-2:0], lfsr_state[TAP_HI] ^ lfsr_state[TAP_LO]};
        end
    end

    assign lfsr_bit = lfsr_state[TAP_HI];

endmodule

// File: rtl/mseq_frame_ctrl.sv
// Frame controller: sends a fixed preamble followed by frame_len LFSR
// payload bits over a valid/ready serial link.
// Optional build macro MSEQ_DIFF_EN: payload bits are differentially
// encoded against the last transmitted payload bit (reference 0 at
// payload entry). The preamble is always sent raw.
module mseq_frame_ctrl
    import mseq_pkg::*;
#(
    parameter int          LEN_W   = 16,
    parameter int          PRE_LEN = 8,
    parameter logic [31:0] PRE_PAT = 32'h0000_00A5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic [LFSR_W-1:0]  seed,
    input  logic               abort,
    mseq_frame_ctrl_if.master  bit_if,
    output logic               busy,
    output logic               done,
    output state_e             state_dbg
);

    localparam logic [31:0]      PAT      = PRE_PAT;
    localparam logic [4:0]       PRE_LAST = 5'(PRE_LEN - 1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_e             state;
    logic [4:0]         pre_cnt;
    logic [4:0]         pre_idx;
    logic [LEN_W-1:0]   pay_cnt;
    logic [LEN_W-1:0]   len_q;
    logic [LFSR_W-1:0]  seed_q;
    logic               valid_q;
    logic               hs;
    logic               pre_bit;
    logic               pay_bit;
    logic               out_bit;
    logic               lfsr_bit;
    logic               lfsr_load;
    logic               lfsr_adv;

    assign hs        = valid_q & bit_if.bit_ready;
    assign lfsr_load = (state == LOAD);
    assign lfsr_adv  = (state == PAYLOAD) & hs & ~abort;

    // Preamble goes out MSB first from the low PRE_LEN bits of the pattern
    assign pre_idx = PRE_LAST - pre_cnt;
    assign pre_bit = PAT[pre_idx];

    mseq_lfsr15 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .seed     (seed_q),
        .advance  (lfsr_adv),
        .lfsr_bit (lfsr_bit)
    );

`ifdef MSEQ_DIFF_EN
    logic diff_ref;

    // Last transmitted payload bit; held at 0 outside PAYLOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_ref <= 1'b0;
        end else if (state != PAYLOAD) begin
            diff_ref <= 1'b0;
        end else if (hs) begin
            diff_ref <= out_bit;
        end
    end

    assign pay_bit = lfsr_bit ^ diff_ref;
`else
    assign pay_bit = lfsr_bit;
`endif

    // Output bit is a pure decode of registers, so it cannot change while stalled
    assign out_bit = valid_q & ((state == PAYLOAD) ? pay_bit : pre_bit);

    assign bit_if.bit_out   = out_bit;
    assign bit_if.bit_valid = valid_q;
    assign state_dbg        = state;

    // Frame FSM: reset beats abort, abort beats start and handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pre_cnt <= '0;
            pay_cnt <= '0;
            len_q   <= '0;
            seed_q  <= DEFAULT_SEED;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            pre_cnt <= '0;
            pay_cnt <= '0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        len_q  <= frame_len;
                        seed_q <= seed;
                        busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    state   <= PREAMBLE;
                    pre_cnt <= '0;
                    valid_q <= 1'b1;
                end
                PREAMBLE: begin
                    if (hs) begin
                        if (pre_cnt == PRE_LAST) begin
                            pre_cnt <= '0;
                            pay_cnt <= '0;
                            if (len_q == '0) begin
                                state   <= DONE;
                                valid_q <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end else begin
                            pre_cnt <= pre_cnt + 5'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (hs) begin
                        // compare against len-1 so the counter never wraps
                        if (pay_cnt == len_q - LEN_ONE) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            done    <= 1'b1;
                            pay_cnt <= '0;
                        end else begin
                            pay_cnt <= pay_cnt + LEN_ONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mseq_frame_ctrl.sv
// Directed bench for mseq_frame_ctrl (default 16-bit length instance plus a
// 4-bit length instance for the maximum-length case).
module tb_mseq_frame_ctrl;
    import mseq_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] frame_len;
    logic [14:0] seed;
    logic        busy;
    logic        done;
    state_e      state_dbg;

    logic        start4;
    logic        abort4;
    logic [3:0]  frame_len4;
    logic        busy4;
    logic        done4;
    state_e      state4;

    mseq_frame_ctrl_if bif ();
    mseq_frame_ctrl_if bif4 ();

    mseq_frame_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .seed      (seed),
        .abort     (abort),
        .bit_if    (bif.master),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    mseq_frame_ctrl #(.LEN_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .frame_len (frame_len4),
        .seed      (seed),
        .abort     (abort4),
        .bit_if    (bif4.master),
        .busy      (busy4),
        .done      (done4),
        .state_dbg (state4)
    );

    // ---------------- scoreboard ----------------
`ifdef MSEQ_DIFF_EN
    localparam logic [14:0] EXP_PAY = 15'b010110100101101;
`else
    localparam logic [14:0] EXP_PAY = 15'b011101110111011;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [0:0]  exp_q[$];
    logic [0:0]  got_q[$];
    logic [22:0] exp_full;

    int f_bits, f_done, f_lat, f_stall;
    bit f_aborted;

    task automatic fill_exp(input int nbits);
        exp_q.delete();
        for (int i = 0; i < nbits; i++) exp_q.push_back(exp_full[22-i]);
    endtask

    // ---------------- driver ----------------
    // mode 0: ready always 1; mode 1: ready toggles each cycle.
    // abort_after >= 0 aborts once that many payload bits have transferred.
    task automatic run_frame(input logic [15:0] len, input logic [14:0] sd,
                             input int mode, input int abort_after, input bit busy_start,
                             output int n_bits, output int n_done, output int lat,
                             output int stall_err, output bit aborted);
        int   cyc;
        bit   seen;
        bit   prev_stall;
        logic prev_bit;
        got_q.delete();
        n_bits = 0; n_done = 0; lat = -1; stall_err = 0; aborted = 0;
        seen = 0; prev_stall = 0; prev_bit = 1'b0;
        frame_len = len; seed = sd; start = 1'b1; bif.bit_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            if (done === 1'b1) begin
                n_done++;
                if (!seen) lat = cyc;
                seen = 1;
            end
            if (seen && busy === 1'b0) break;
            if (busy_start) begin
                if (cyc >= 3 && cyc <= 6) begin
                    start = 1'b1; frame_len = 16'd3; seed = 15'h1234;
                end else begin
                    start = 1'b0;
                end
            end
            bif.bit_ready = (mode == 0) ? 1'b1 : cyc[0];
            if (prev_stall && bif.bit_valid === 1'b1 && bif.bit_out !== prev_bit) stall_err++;
            if (abort_after >= 0 && n_bits == 8 + abort_after) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                aborted = 1;
                break;
            end
            if (bif.bit_valid === 1'b1 && bif.bit_ready === 1'b1) begin
                got_q.push_back(bif.bit_out);
                n_bits++;
            end
            prev_stall = (bif.bit_valid === 1'b1) && (bif.bit_ready === 1'b0);
            prev_bit   = bif.bit_out;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        bif.bit_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; frame_len = '0; seed = '0;
        bif.bit_ready = 1'b0;
        start4 = 1'b0; abort4 = 1'b0; frame_len4 = '0; bif4.bit_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
        n_checks++; if (bif.bit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bif.bit_valid); end
        n_checks++; if (bif.bit_out !== 1'b0) begin n_fail++; $display("FAIL reset_bit_out: got %b expected 0", bif.bit_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_ready();
        run_frame(16'd15, 15'h3BBB, 0, -1, 0, f_bits, f_done, f_lat, f_stall, f_aborted);
        fill_exp(23);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < 23 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_bit[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (f_done !== 1) begin n_fail++; $display("FAIL full_done_pulses: got %0d expected 1", f_done); end
        n_checks++; if (f_lat !== 24) begin n_fail++; $display("FAIL full_latency: got %0d expected 24", f_lat); end
    endtask

    task automatic test_toggle_ready();
        run_frame(16'd15, 15'h3BBB, 1, -1, 0, f_bits, f_done, f_lat, f_stall, f_aborted);
        fill_exp(23);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL toggle_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < 23 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL toggle_bit[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (f_stall !== 0) begin n_fail++; $display("FAIL toggle_stall_stable: got %0d changes expected 0", f_stall); end
        n_checks++; if (f_done !== 1) begin n_fail++; $display("FAIL toggle_done_pulses: got %0d expected 1", f_done); end
        n_checks++; if (f_lat < 45 || f_lat > 47) begin n_fail++; $display("FAIL toggle_latency: got %0d expected 45..47", f_lat); end
    endtask

    task automatic test_len_zero();
        run_frame(16'd0, 15'h3BBB, 0, -1, 0, f_bits, f_done, f_lat, f_stall, f_aborted);
        fill_exp(8);
        n_checks++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL len0_count: got %0d expected 8", got_q.size()); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL len0_bit[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (f_done !== 1) begin n_fail++; $display("FAIL len0_done_pulses: got %0d expected 1", f_done); end
        n_checks++; if (f_lat !== 9) begin n_fail++; $display("FAIL len0_latency: got %0d expected 9", f_lat); end
    endtask

    task automatic test_abort();
        int extra_done;
        run_frame(16'd15, 15'h3BBB, 0, 3, 0, f_bits, f_done, f_lat, f_stall, f_aborted);
        n_checks++; if (f_aborted !== 1'b1) begin n_fail++; $display("FAIL abort_reached: got %b expected 1", f_aborted); end
        n_checks++; if (bif.bit_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", bif.bit_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL abort_state: got %0d expected %0d", state_dbg, IDLE); end
        extra_done = f_done;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) extra_done++;
            @(posedge clk); #1;
        end
        n_checks++; if (extra_done !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", extra_done); end
        fill_exp(11);
        for (int i = 0; i < 11 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL abort_bit[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
        end
        // replay must restart the sequence from the seed
        run_frame(16'd15, 15'h3BBB, 0, -1, 0, f_bits, f_done, f_lat, f_stall, f_aborted);
        fill_exp(23);
        n_checks++; if (got_q.size() !== 23) begin n_fail++; $display("FAIL replay_count: got %0d expected 23", got_q.size()); end
        for (int i = 0; i < 23 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL replay_bit[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (f_done !== 1) begin n_fail++; $display("FAIL replay_done_pulses: got %0d expected 1", f_done); end
    endtask

    task automatic test_seed_zero_busy_start();
        run_frame(16'd15, 15'h0000, 0, -1, 1, f_bits, f_done, f_lat, f_stall, f_aborted);
        fill_exp(23);
        n_checks++; if (got_q.size() !== 23) begin n_fail++; $display("FAIL seed0_count: got %0d expected 23", got_q.size()); end
        for (int i = 0; i < 23 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL seed0_bit[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (f_done !== 1) begin n_fail++; $display("FAIL seed0_done_pulses: got %0d expected 1", f_done); end
        n_checks++; if (f_lat !== 24) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 24", f_lat); end
        n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL busy_start_idle: got %0d expected %0d", state_dbg, IDLE); end
    endtask

    task automatic test_abort_start_idle();
        frame_len = 16'd15; seed = 15'h3BBB;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL abort_start_state: got %0d expected %0d", state_dbg, IDLE); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        n_checks++; if (bif.bit_valid !== 1'b0) begin n_fail++; $display("FAIL abort_start_valid: got %b expected 0", bif.bit_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int seen_busy;
        frame_len = 16'd15; seed = 15'h3BBB; start = 1'b1; bif.bit_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_checks++; if (state_dbg !== PAYLOAD) begin n_fail++; $display("FAIL rst_mid_setup: got %0d expected %0d", state_dbg, PAYLOAD); end
        rst = 1'b1; abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; abort = 1'b0; start = 1'b0;
        n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected %0d", state_dbg, IDLE); end
        n_checks++; if (bif.bit_valid !== 1'b0 || bif.bit_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got valid %b bit %b expected 0 0", bif.bit_valid, bif.bit_out); end
        seen_busy = 0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen_busy++;
            @(posedge clk); #1;
        end
        n_checks++; if (seen_busy !== 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d busy/done cycles expected 0", seen_busy); end
        bif.bit_ready = 1'b0;
    endtask

    task automatic test_max_len();
        int n_done4;
        bit seen;
        got_q.delete();
        n_done4 = 0; seen = 0;
        seed = 15'h3BBB; frame_len4 = 4'hF; start4 = 1'b1; bif4.bit_ready = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (done4 === 1'b1) begin n_done4++; seen = 1; end
            if (seen && busy4 === 1'b0) break;
            if (bif4.bit_valid === 1'b1 && bif4.bit_ready === 1'b1) got_q.push_back(bif4.bit_out);
            @(posedge clk); #1;
        end
        bif4.bit_ready = 1'b0;
        fill_exp(23);
        n_checks++; if (got_q.size() !== 23) begin n_fail++; $display("FAIL maxlen_count: got %0d expected 23", got_q.size()); end
        for (int i = 0; i < 23 && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL maxlen_bit[%0d]: got %b expected %b", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (n_done4 !== 1) begin n_fail++; $display("FAIL maxlen_done_pulses: got %0d expected 1", n_done4); end
        n_checks++; if (state4 !== IDLE) begin n_fail++; $display("FAIL maxlen_idle: got %0d expected %0d", state4, IDLE); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        exp_full = {8'hA5, EXP_PAY};
        test_reset();
        test_full_ready();
        test_toggle_ready();
        test_len_zero();
        test_abort();
        test_seed_zero_busy_start();
        test_abort_start_idle();
        test_reset_mid_frame();
        test_max_len();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mseq_frame_ctrl.md
MSEQ_FRAME_CTRL -- requirements
Module: mseq_frame_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 16: width of the payload length field.
REQ-002 SHALL have parameter PRE_LEN, default 8: preamble length in bits (1..32).
REQ-003 SHALL have parameter PRE_PAT, default 32'h0000_00A5: preamble pattern; low PRE_LEN bits used, sent MSB first.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: frame request; honoured only in IDLE.
REQ-007 SHALL have port frame_len, input, LEN_W: payload bit count; sampled on an accepted start.
REQ-008 SHALL have port seed, input, 15: LFSR seed; sampled on an accepted start.
REQ-009 SHALL have port abort, input, 1: terminates the frame.
REQ-010 SHALL have port bit_out, output, 1: serial bit to the modulator.
REQ-011 SHALL have port bit_valid, output, 1: bit_out is valid.
REQ-012 SHALL have port bit_ready, input, 1: modulator accepts the bit.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at normal frame end.

Function
REQ-015 SHALL implement states IDLE, LOAD, PREAMBLE, PAYLOAD and DONE.
REQ-016 SHALL leave IDLE for LOAD one cycle after start=1, and capture frame_len and seed in that cycle.
REQ-017 SHALL write seed into the LFSR in LOAD, replacing an all-zero seed with 15'h3BBB, then enter PREAMBLE.
REQ-018 SHALL use LFSR x^15+x^14+1: output = state[14]; next = {state[13:0], state[14]^state[13]}.
REQ-019 SHALL count a handshake only when bit_valid and bit_ready are both 1 in the same cycle.
REQ-020 SHALL keep bit_out stable while bit_valid=1 and bit_ready=0.
REQ-021 SHALL drive PRE_PAT bits in PREAMBLE; after PRE_LEN handshakes SHALL go to PAYLOAD, or to DONE if frame_len=0.
REQ-022 SHALL drive the LFSR output in PAYLOAD and advance the LFSR only on a handshake.
REQ-023 SHALL go to DONE after frame_len payload handshakes.
REQ-024 SHALL assert done for the single DONE cycle, then return to IDLE.
REQ-025 SHALL keep bit_valid=1 only in PREAMBLE and PAYLOAD.
REQ-026 SHALL, on abort=1 in any state, enter IDLE next cycle with bit_valid=0 and no done pulse.
REQ-027 SHALL let abort win when abort and start are both 1 in IDLE.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL hold the payload counter at LEN_W bits; frame_len = 2^LEN_W-1 SHALL complete without wrap.

Reset
REQ-030 SHALL, on rst=1, force state IDLE, bit_out=0, bit_valid=0, busy=0, done=0, counters 0 and LFSR 15'h3BBB.
REQ-031 SHALL let rst mid-frame take priority over abort, start and the handshake, and drop the frame with no done pulse.

Configuration
REQ-032 SHALL, with MSEQ_DIFF_EN defined, send payload bits differentially encoded: bit_out = lfsr_bit XOR last transmitted bit, reference 0 at PAYLOAD entry.
REQ-033 SHALL, without MSEQ_DIFF_EN, send raw LFSR bits; the preamble SHALL never be differentially encoded.

Structure
REQ-034 SHALL place the state enum, LFSR width 15, the tap positions and the default seed 15'h3BBB in package mseq_pkg.
REQ-035 SHALL instance the LFSR as sub-module mseq_lfsr15, with ports load, seed, advance and bit.

Verification
REQ-036 SHALL check: seed=15'h3BBB, frame_len=15, bit_ready=1 -> bits A5 MSB-first, then 0,1,1,1,0,1,1,1,0,1,1,1,0,1,1, then one done pulse.
REQ-037 SHALL check: bit_ready toggled 1/0 every cycle -> same 23-bit stream, bit_out stable in stalled cycles, done 46±1 cycles after start.
REQ-038 SHALL check: frame_len=0 -> 8 preamble bits, then DONE, with no payload bit.
REQ-039 SHALL check: abort after 3 payload bits -> next cycle bit_valid=0 and busy=0, no done; a new start replays the same seed stream.
REQ-040 SHALL check: seed=0 -> stream identical to seed=15'h3BBB; start while busy -> ignored.
REQ-041 SHALL check: MSEQ_DIFF_EN defined, seed=15'h3BBB -> first payload bits 0,1,0,1,1,0,1,0.
